serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 115 +++++++++++
 tb/tb_serial_subtractor.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - B_IN, one bit per clock, LSB first.
// A single full-subtractor cell is reused with a registered borrow; START/BUSY/DONE handshake.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             B_IN,
    output logic [WIDTH-1:0] DIFF,
    output logic             B_OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // One full-subtractor cell: returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic bin);
        logic d;
        logic bout;
        d    = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
        return {bout, d};
    endfunction

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-2:0]   res_r;
    logic               borrow_r;
    logic [CNT_W-1:0]   count_r;

    logic [1:0]         cell_s;
    logic               d_s;
    logic               borrow_next_s;
    logic [WIDTH-1:0]   res_next_s;
    logic               last_s;

    // Current bit of the subtraction and the result register as it will look after this edge.
    always_comb begin
        cell_s        = full_sub(a_sh_r[0], b_sh_r[0], borrow_r);
        d_s           = cell_s[0];
        borrow_next_s = cell_s[1];
        res_next_s    = {d_s, res_r};
        if (count_r == CNT_W'(WIDTH - 1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Handshake FSM, operand/result shifting and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r  <= IDLE;
            a_sh_r   <= {WIDTH{1'b0}};
            b_sh_r   <= {WIDTH{1'b0}};
            res_r    <= {(WIDTH-1){1'b0}};
            borrow_r <= 1'b0;
            count_r  <= {CNT_W{1'b0}};
            DIFF     <= {WIDTH{1'b0}};
            B_OUT    <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (START) begin
                        a_sh_r   <= A;
                        b_sh_r   <= B;
                        borrow_r <= B_IN;
                        count_r  <= {CNT_W{1'b0}};
                        BUSY     <= 1'b1;
                        state_r  <= SHIFT;
                    end else begin
                        BUSY     <= 1'b0;
                        state_r  <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r    <= res_next_s[WIDTH-1:1];
                    borrow_r <= borrow_next_s;
                    count_r  <= count_r + CNT_W'(1);
                    if (last_s) begin
                        // Final bit: publish result and borrow together with the DONE pulse.
                        DIFF    <= res_next_s;
                        B_OUT   <= borrow_next_s;
                        DONE    <= 1'b1;
                        BUSY    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        BUSY    <= 1'b1;
                        state_r <= SHIFT;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed vector table,
// multi-cycle corner sequences and an exhaustive sweep against an arithmetic reference.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       b_in;
    logic [3:0] diff;
    logic       b_out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(4)) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .A     (a),
        .B     (b),
        .B_IN  (b_in),
        .DIFF  (diff),
        .B_OUT (b_out),
        .BUSY  (busy),
        .DONE  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with BUSY expected high; returns at the negedge where BUSY fell.
    task automatic wait_done(output int cycles);
        int guard;
        cycles = 0;
        guard  = 0;
        while (busy === 1'b1 && guard < 50) begin
            cycles++;
            guard++;
            @(negedge clk);
        end
    endtask

    // Issue one op from IDLE at a negedge and wait for it to finish.
    task automatic do_op(input logic [3:0] av, input logic [3:0] bv, input logic bi,
                         output int cycles);
        a = av; b = bv; b_in = bi; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(cycles);
    endtask

    initial begin
        int         cyc;
        int         done_seen;
        logic [4:0] ref5;
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] held;

        vecs[0] = '{4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b0};
        vecs[1] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1};
        vecs[2] = '{4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1};
        vecs[3] = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0};
        vecs[4] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vecs[5] = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0};

        rst = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0; b_in = 1'b0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("reset_diff", 32'(diff), 32'd0);
        check("reset_bout", 32'(b_out), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].bin, cyc);
            check("vec_busy_len", 32'(cyc), 32'd4);
            check("vec_done", 32'(done), 32'd1);
            check("vec_diff", 32'(diff), 32'(vecs[i].diff));
            check("vec_bout", 32'(b_out), 32'(vecs[i].bout));
            @(negedge clk);
            check("vec_done_pulse", 32'(done), 32'd0);
        end

        // Make the held value distinctive before the restart-ignore test
        do_op(4'b1100, 4'b0001, 1'b0, cyc);
        check("pre_diff", 32'(diff), 32'd11);
        held = diff;
        @(negedge clk);

        // START during BUSY is ignored; DIFF held until DONE
        a = 4'b0111; b = 4'b0001; b_in = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 4'b1111; b = 4'b1110; b_in = 1'b0;
        done_seen = 0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 50) begin
            check("hold_diff", 32'(diff), 32'(held));
            if (cyc == 1) start = 1'b0;
            cyc++;
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_busy_len", 32'(cyc), 32'd4);
        check("ign_done", 32'(done), 32'd1);
        check("ign_diff", 32'(diff), 32'b0101);
        check("ign_bout", 32'(b_out), 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("ign_single_done", 32'(done_seen), 32'd0);
        check("ign_idle", 32'(busy), 32'd0);

        // Back-to-back: START raised while DONE is high
        do_op(4'b0101, 4'b0011, 1'b0, cyc);
        check("b2b_first_done", 32'(done), 32'd1);
        a = 4'b1000; b = 4'b0001; b_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_no_gap", 32'(busy), 32'd1);
        wait_done(cyc);
        check("b2b_busy_len", 32'(cyc), 32'd4);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_diff", 32'(diff), 32'b0111);
        check("b2b_bout", 32'(b_out), 32'd0);
        @(negedge clk);

        // Reset two edges into an operation aborts it
        a = 4'b1111; b = 4'b0001; b_in = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_diff", 32'(diff), 32'd0);
        check("abort_bout", 32'(b_out), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        do_op(4'd9, 4'd4, 1'b0, cyc);
        check("post_abort_diff", 32'(diff), 32'b0101);
        check("post_abort_bout", 32'(b_out), 32'd0);
        @(negedge clk);

        // Exhaustive sweep against arithmetic reference
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    av   = 4'(ia);
                    bv   = 4'(ib);
                    ref5 = {1'b0, av} - {1'b0, bv} - {4'b0000, 1'(ic)};
                    do_op(av, bv, 1'(ic), cyc);
                    check("ex_busy_len", 32'(cyc), 32'd4);
                    check("ex_done", 32'(done), 32'd1);
                    check("ex_diff", 32'(diff), 32'(ref5[3:0]));
                    check("ex_bout", 32'(b_out), 32'(ref5[4]));
                    @(negedge clk);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
